// File: rtl/controller_sequencer_if.sv
// Control-word bundle between the SAP-I sequencer and the bus registers it steers.
// The sequencer uses the master modport; the datapath (or bench) uses the slave modport.
interface controller_sequencer_if;
  logic [3:0] opcode;
  logic       Cp;
  logic       Ep;
  logic       nLm;
  logic       nCE;
  logic       nLi;
  logic       nEi;
  logic       nLa;
  logic       Ea;
  logic       Su;
  logic       Eu;
  logic       nLb;
  logic       nLo;
  logic       HLT;
  logic [5:0] T;

  modport master (
    input  opcode,
    output Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT, T
  );

  modport slave (
    output opcode,
    input  Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT, T
  );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-I control unit: one-hot T1..T6 ring stepping on the falling edge of CLK,
// with the control word decoded combinationally from T, the halt latch and the opcode.
module controller_sequencer (
  input  logic                          CLK,
  input  logic                          CLR,
  controller_sequencer_if.master        bus
);
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halt_q, halt_d;
  logic    hlt_now;

  // Falling-edge state keeps the control word settled across every rising edge.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    hlt_now = halt_q | ((state_q == T4) && (bus.opcode == OP_HLT));
    state_d = state_q;
    halt_d  = halt_q;
    bus.Cp  = 1'b0;
    bus.Ep  = 1'b0;
    bus.nLm = 1'b1;
    bus.nCE = 1'b1;
    bus.nLi = 1'b1;
    bus.nEi = 1'b1;
    bus.nLa = 1'b1;
    bus.Ea  = 1'b0;
    bus.Su  = 1'b0;
    bus.Eu  = 1'b0;
    bus.nLb = 1'b1;
    bus.nLo = 1'b1;
    bus.HLT = hlt_now;
    bus.T   = state_q;

    if (hlt_now) begin
      // Frozen in T4 with an inactive word until CLR.
      halt_d = 1'b1;
    end else begin
      case (state_q)
        T1: begin
          state_d = T2;
          bus.Ep  = 1'b1;
          bus.nLm = 1'b0;
        end
        T2: begin
          state_d = T3;
          bus.Cp  = 1'b1;
        end
        T3: begin
          state_d = T4;
          bus.nCE = 1'b0;
          bus.nLi = 1'b0;
        end
        T4: begin
          state_d = T5;
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              bus.nLm = 1'b0;
              bus.nEi = 1'b0;
            end
            OP_OUT: begin
              bus.Ea  = 1'b1;
              bus.nLo = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          state_d = T6;
          case (bus.opcode)
            OP_LDA: begin
              bus.nCE = 1'b0;
              bus.nLa = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              bus.nCE = 1'b0;
              bus.nLb = 1'b0;
              bus.Su  = (bus.opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        T6: begin
          state_d = T1;
          case (bus.opcode)
            OP_ADD, OP_SUB: begin
              bus.Eu  = 1'b1;
              bus.nLa = 1'b0;
              bus.Su  = (bus.opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        // Any non-one-hot pattern: inactive word, recover to T1.
        default: state_d = T1;
      endcase
    end
  end
endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: driver pushes the expected control word
// for each T-state, a rising-edge monitor pops and compares, plus one-hot/contention checks.
module tb_controller_sequencer;
  typedef struct packed {
    logic       cp, ep, nlm, nce, nli, nei, nla, ea, su, eu, nlb, nlo, hlt;
    logic [5:0] t;
  } word_t;

  localparam int W = $bits(word_t);

  logic CLK;
  logic CLR;
  int   tests;
  int   fails;

  logic [W-1:0] exp_q[$];

  int   m_t;
  bit   m_halt;

  controller_sequencer_if bus();

  controller_sequencer dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  function automatic word_t actual_word();
    word_t w;
    w = '{bus.Cp, bus.Ep, bus.nLm, bus.nCE, bus.nLi, bus.nEi, bus.nLa,
          bus.Ea, bus.Su, bus.Eu, bus.nLb, bus.nLo, bus.HLT, bus.T};
    return w;
  endfunction

  // Hand-written reference of the control word for T-state index ti (0 = T1).
  function automatic word_t model_word(int ti, logic [3:0] op, bit halted);
    word_t w;
    w = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
          1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
    w.t   = 6'(1) << ti;
    w.hlt = halted || (ti == 3 && op == 4'b1111);
    if (!w.hlt) begin
      case (ti)
        0: begin w.ep = 1'b1; w.nlm = 1'b0; end
        1: w.cp = 1'b1;
        2: begin w.nce = 1'b0; w.nli = 1'b0; end
        3: begin
          if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) begin
            w.nlm = 1'b0; w.nei = 1'b0;
          end else if (op == 4'b1110) begin
            w.ea = 1'b1; w.nlo = 1'b0;
          end
        end
        4: begin
          if (op == 4'b0000) begin
            w.nce = 1'b0; w.nla = 1'b0;
          end else if (op == 4'b0001 || op == 4'b0010) begin
            w.nce = 1'b0; w.nlb = 1'b0; w.su = (op == 4'b0010);
          end
        end
        5: begin
          if (op == 4'b0001 || op == 4'b0010) begin
            w.eu = 1'b1; w.nla = 1'b0; w.su = (op == 4'b0010);
          end
        end
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: act=%h req=%h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare on every rising edge, where bus registers would sample.
  always @(posedge CLK) begin
    word_t a, e;
    int drivers;
    a = actual_word();
    if (exp_q.size() > 0) begin
      e = word_t'(exp_q.pop_front());
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL word: act=%h req=%h @%0t", a, e, $time);
      end
    end
    tests++;
    if (!$onehot(a.t)) begin
      fails++;
      $display("FAIL onehot: act=%b req=one-hot @%0t", a.t, $time);
    end
    drivers = int'(a.ep) + int'(!a.nce) + int'(!a.nei) + int'(a.ea) + int'(a.eu);
    tests++;
    if (drivers > 1) begin
      fails++;
      $display("FAIL contention: act=%0d drivers req<=1 @%0t", drivers, $time);
    end
  end

  // Driver: push the expected word for the current T-state, then step one falling edge.
  task automatic cycle(input logic [3:0] op);
    bus.opcode = op;
    exp_q.push_back(model_word(m_t, op, m_halt));
    @(negedge CLK);
    #1;
    if (m_halt || (m_t == 3 && op == 4'b1111)) m_halt = 1'b1;
    else m_t = (m_t + 1) % 6;
  endtask

  task automatic run_instr(input logic [3:0] op);
    while (m_t != 0) cycle(4'b0000);
    for (int i = 0; i < 6; i++) cycle(op);
  endtask

  // Asynchronous CLR between edges; leaves the model at T2 after one ring step.
  task automatic pulse_clr();
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_async_T", {26'd0, bus.T}, 32'h01);
    chk("clr_async_Ep", {31'd0, bus.Ep}, 32'd1);
    chk("clr_async_HLT", {31'd0, bus.HLT}, 32'd0);
    m_t = 0;
    m_halt = 1'b0;
    exp_q.push_back(model_word(0, bus.opcode, 1'b0));
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    @(negedge CLK);
    #1;
    m_t = 1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_t = 0;
    m_halt = 1'b0;
    CLR = 1'b1;
    bus.opcode = 4'b0000;
    #1;
    chk("reset_T", {26'd0, bus.T}, 32'h01);
    chk("reset_HLT", {31'd0, bus.HLT}, 32'd0);
    #1;
    CLR = 1'b0;

    // 1..3: LDA, ADD, SUB, OUT, and an undefined opcode
    run_instr(4'b0000);
    chk("wrap_T1", {26'd0, bus.T}, 32'h01);
    run_instr(4'b0001);
    run_instr(4'b0010);
    run_instr(4'b1110);
    run_instr(4'b0101);

    // 4: HLT freezes in T4 for 20 clocks, CLR releases it
    for (int i = 0; i < 3; i++) cycle(4'b1111);
    for (int i = 0; i < 21; i++) cycle(4'b1111);
    chk("halt_T", {26'd0, bus.T}, 32'h08);
    chk("halt_HLT", {31'd0, bus.HLT}, 32'd1);
    pulse_clr();
    while (m_t != 0) cycle(4'b0000);

    // 5: CLR during ADD T6
    for (int i = 0; i < 5; i++) cycle(4'b0001);
    chk("pre_clr_T6", {26'd0, bus.T}, 32'h20);
    chk("pre_clr_nLa", {31'd0, bus.nLa}, 32'd0);
    pulse_clr();
    chk("post_clr_nLa", {31'd0, bus.nLa}, 32'd1);
    while (m_t != 0) cycle(4'b0001);

    // 6: random non-halting opcodes
    for (int n = 0; n < 500; n++) run_instr(4'($urandom_range(0, 14)));

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
